// File: rtl/regfile_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_port_arbiter
// Purpose  : Owns the RV32I register file write port and read port A. Shares
//            them between pipeline writeback, a req/ack debug channel and an
//            internal sweep that zeroes x1..x(NREG-1) after reset or on demand.
//            Debug accesses stall and drain the pipeline before they are served.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_port_arbiter #(
    parameter int XLEN      = 32,
    parameter int AW        = 5,
    parameter int DRAIN_CYC = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_req,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic [AW-1:0]   id_addra,
    input  logic            dbg_req,
    input  logic            dbg_we,
    input  logic [AW-1:0]   dbg_addr,
    input  logic [XLEN-1:0] dbg_wdata,
    output logic            dbg_ack,
    output logic [XLEN-1:0] dbg_rdata,
    output logic            rf_we,
    output logic [AW-1:0]   rf_addrd,
    output logic [XLEN-1:0] rf_datad,
    output logic [AW-1:0]   rf_addra,
    input  logic [XLEN-1:0] rf_dataa,
    output logic            stall,
    output logic            busy
);

    // Drain counter counts DRAIN_CYC down to zero; keep at least one bit.
    localparam int unsigned        c_cnt_w      = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_drain_load = c_cnt_w'(DRAIN_CYC);
    localparam logic [AW-1:0]      c_first_idx  = AW'(1);
    localparam logic [AW-1:0]      c_last_idx   = {AW{1'b1}};

    typedef enum logic [2:0] {
        S_CLEAR  = 3'd0,
        S_IDLE   = 3'd1,
        S_DRAIN  = 3'd2,
        S_ACCESS = 3'd3,
        S_ACK    = 3'd4
    } state_t;

    state_t              r_state;
    logic [AW-1:0]       r_clr_idx;
    logic                r_clr_pend;
    logic [c_cnt_w-1:0]  r_drain_cnt;
    logic [XLEN-1:0]     r_dbg_rdata;

    logic                w_we;
    logic [AW-1:0]       w_addrd;
    logic [XLEN-1:0]     w_datad;
    logic [AW-1:0]       w_addra;
    logic                w_dbg_wr_port;
    logic                w_dbg_wr_blocked;

    // A debug write to x0 is acknowledged but never needs the write port.
    assign w_dbg_wr_port    = dbg_we && (dbg_addr != '0);
    // Writeback always wins the write port; the debug write retries next cycle.
    assign w_dbg_wr_blocked = w_dbg_wr_port && wb_we;

    // Port mux: writeback/decode by default, overridden by the sweep or a debug access.
    always_comb begin
        w_we    = wb_we;
        w_addrd = wb_addr;
        w_datad = wb_data;
        w_addra = id_addra;
        case (r_state)
            S_CLEAR: begin
                w_we    = 1'b1;
                w_addrd = r_clr_idx;
                w_datad = '0;
            end
            S_ACCESS: begin
                if (dbg_we) begin
                    if (w_dbg_wr_port && !wb_we) begin
                        w_we    = 1'b1;
                        w_addrd = dbg_addr;
                        w_datad = dbg_wdata;
                    end
                end else begin
                    w_addra = dbg_addr;
                end
            end
            default: ;
        endcase
    end

    // Write enable is forced low for as long as reset is held.
    assign rf_we     = w_we & ~rst;
    assign rf_addrd  = w_addrd;
    assign rf_datad  = w_datad;
    assign rf_addra  = w_addra;
    assign dbg_ack   = (r_state == S_ACK);
    assign dbg_rdata = r_dbg_rdata;
    assign stall     = (r_state != S_IDLE);
    assign busy      = (r_state != S_IDLE);

    // Arbiter state machine: sweep, idle, drain, debug access, acknowledge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_CLEAR;
            r_clr_idx   <= c_first_idx;
            r_clr_pend  <= 1'b0;
            r_drain_cnt <= '0;
            r_dbg_rdata <= '0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_clr_idx <= r_clr_idx + AW'(1);
                    if (r_clr_idx == c_last_idx) begin
                        r_state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (clr_req || r_clr_pend) begin
                        r_state    <= S_CLEAR;
                        r_clr_idx  <= c_first_idx;
                        r_clr_pend <= 1'b0;
                    end else if (dbg_req) begin
                        r_state     <= S_DRAIN;
                        r_drain_cnt <= c_drain_load;
                    end
                end
                S_DRAIN: begin
                    if (clr_req) begin
                        r_clr_pend <= 1'b1;
                    end
                    if (!dbg_req) begin
                        r_state <= S_IDLE;
                    end else if (r_drain_cnt == '0) begin
                        r_state <= S_ACCESS;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - c_cnt_w'(1);
                    end
                end
                S_ACCESS: begin
                    if (clr_req) begin
                        r_clr_pend <= 1'b1;
                    end
                    if (!dbg_we) begin
                        r_dbg_rdata <= rf_dataa;
                        r_state     <= S_ACK;
                    end else if (!w_dbg_wr_blocked) begin
                        r_state <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (clr_req || r_clr_pend) begin
                        r_state    <= S_CLEAR;
                        r_clr_idx  <= c_first_idx;
                        r_clr_pend <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_CLEAR;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/regfile_port_arbiter.md
Name: regfile_port_arbiter

Overview:
- Owns the write port and read port A of the RV32I register file.
- Shares these ports between three users: the pipeline writeback stage, a debug/GUI access channel, and an internal clear sequencer.
- After reset, or on request, it sweeps x1..x31 to zero.
- It stalls the pipeline and drains it before serving a debug read or write. Debug accesses use a req/ack handshake.

Parameters:
- XLEN, 32, data width.
- AW, 5, register address width (NREG = 2**AW).
- DRAIN_CYC, 3, cycles stall is held before a debug access so in-flight writebacks retire.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- clr_req  in  1  one-cycle pulse; request a full register clear.
- wb_we  in  1  pipeline writeback enable.
- wb_addr  in  AW  writeback destination.
- wb_data  in  XLEN  writeback data.
- id_addra  in  AW  decode-stage read address A.
- dbg_req  in  1  debug request, level; held until dbg_ack.
- dbg_we  in  1  1 = write, 0 = read; stable while dbg_req is high.
- dbg_addr  in  AW  debug register address.
- dbg_wdata  in  XLEN  debug write data.
- dbg_ack  out  1  one-cycle completion pulse.
- dbg_rdata  out  XLEN  registered read data; valid while dbg_ack is high, then held.
- rf_we  out  1  to regfile WE.
- rf_addrd  out  AW  to regfile AddD.
- rf_datad  out  XLEN  to regfile DataD.
- rf_addra  out  AW  to regfile AddA.
- rf_dataa  in  XLEN  from regfile DataA.
- stall  out  1  freeze the pipeline front end.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, active-high):
  - state = CLEAR, clr_idx = 1, clr_pend = 0.
  - dbg_ack = 0, dbg_rdata = 0.
  - stall = 1, busy = 1.
  - rf_we = 0 while rst is asserted.
- States are CLEAR, IDLE, DRAIN, ACCESS, ACK.
- CLEAR:
  - Each cycle: rf_we = 1, rf_addrd = clr_idx, rf_datad = 0; clr_idx increments.
  - After idx 31 is written, go to IDLE. This takes 31 cycles; x0 is never written.
  - wb_we is dropped. dbg_req is ignored.
  - stall = 1.
- IDLE:
  - rf_we/addrd/datad pass through from wb_*. rf_addra = id_addra. stall = 0.
  - Priority on exit: clr_req or clr_pend goes to CLEAR (clr_idx = 1, clr_pend cleared). Otherwise dbg_req goes to DRAIN with drain counter = DRAIN_CYC.
- DRAIN:
  - stall = 1. Writeback passes through. Counter decrements; at 0, go to ACCESS.
  - If dbg_req drops during DRAIN, return to IDLE with no ack.
- ACCESS (one cycle nominally), stall = 1:
  - Write: rf_we = 1, rf_addrd = dbg_addr, rf_datad = dbg_wdata.
  - Write to x0: rf_we = 0, still acked.
  - Write conflict: if wb_we = 1 in this cycle, writeback wins. Remain in ACCESS and retry the debug write next cycle.
  - Read: rf_addra = dbg_addr; dbg_rdata <= rf_dataa at the clock edge. No write-port conflict, so writeback passes through.
  - Then go to ACK.
- ACK:
  - dbg_ack = 1 for exactly one cycle. stall = 1. Writeback passes through.
  - Next state is IDLE, or CLEAR if clr_pend is set.
  - The requester must deassert dbg_req in the cycle after ack. A dbg_req still high in IDLE starts a new access.
- clr_req handling:
  - In DRAIN, ACCESS or ACK: set clr_pend. It is serviced after ACK.
  - In CLEAR: ignored; the sweep already in progress covers it.
- Debug read latency:
  - dbg_req sampled in IDLE at edge 0.
  - dbg_ack is high in the cycle after edge DRAIN_CYC+2 (default: 5 edges).
  - dbg_rdata is valid in that same cycle.
- Debug write latency: same as read when there is no writeback conflict.
- Reset mid-operation: abort to CLEAR, drop any pending debug access (no ack), restart the sweep.
- Clear plus reset together: reset dominates.

Test Plan:
- Release rst and watch the sweep.
  - Required: rf_we high for exactly 31 cycles with rf_addrd = 1..31 and rf_datad = 0.
  - stall = 1 throughout; the IDLE cycle after has stall = 0.
  - With regfile attached, all registers read 0.
- In IDLE, drive wb_we = 1, wb_addr = 5, wb_data = 0xDEADBEEF; pulse dbg_req read of x5.
  - Required: rf_addra = 5 in ACCESS.
  - dbg_ack pulses 5 edges after req; dbg_rdata = 0xDEADBEEF; stall high from DRAIN through ACK.
- Debug write x10 = 0x12345678 with wb_we = 1 forced in the first ACCESS cycle.
  - Required: writeback applied first; ACCESS repeats once; x10 = 0x12345678; ack at 6 edges.
- Debug write to x0 with data 0xFFFFFFFF.
  - Required: rf_we never asserted with rf_addrd = 0; dbg_ack still pulses; x0 reads 0.
- dbg_req dropped in the 2nd DRAIN cycle.
  - Required: return to IDLE, no dbg_ack, stall falls the next cycle.
- Pulse clr_req during DRAIN, then let the access complete.
  - Required: ack occurs, then CLEAR runs 31 cycles.
- Assert rst mid-CLEAR at idx 12.
  - Required: outputs return to reset values immediately and the sweep restarts at idx 1.
